// File: rtl/count_bits_pkg.sv
// rtl/count_bits_pkg.sv - shared types and helpers for the bit-counting engine
package count_bits_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ONES    = 2'b00,
    ZEROS   = 2'b01,
    LEAD_Z  = 2'b10,
    TRAIL_Z = 2'b11
  } mode_t;

  // Widest operand the reversal helper supports; narrower words are zero-extended.
  localparam int MAX_WORD = 64;

  function automatic logic [MAX_WORD-1:0] bit_reverse(input logic [MAX_WORD-1:0] v);
    logic [MAX_WORD-1:0] r;
    for (int i = 0; i < MAX_WORD; i++) begin
      r[i] = v[MAX_WORD-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_slice_eval.sv
// rtl/bit_slice_eval.sv - combinational popcount / trailing-zero evaluation of one slice
module bit_slice_eval #(
  parameter int STEP = 1,
  parameter int CW   = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] slice,
  output logic [CW-1:0]   popcount,
  output logic [CW-1:0]   tz_count,
  output logic            has_one
);

  always_comb begin
    popcount = '0;
    tz_count = CW'(STEP);
    has_one  = |slice;
    // Scanning downward lets the lowest set bit have the final say.
    for (int i = STEP - 1; i >= 0; i--) begin
      popcount = popcount + CW'(slice[i]);
      if (slice[i]) begin
        tz_count = CW'(i);
      end
    end
  end

endmodule

// File: rtl/count_bits_engine.sv
// rtl/count_bits_engine.sv - multi-mode bit counter with start/busy/done handshake
module count_bits_engine
  import count_bits_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int STEP      = 1,
  localparam int CNT_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [WORD_SIZE-1:0] data,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 busy,
  output logic                 done
);

  localparam int SLICES = WORD_SIZE / STEP;
  localparam int SL_W   = $clog2(SLICES + 1);
  localparam int SC_W   = $clog2(STEP + 1);

  if (STEP < 1 || STEP > WORD_SIZE || (WORD_SIZE % STEP) != 0 || WORD_SIZE > MAX_WORD)
  begin : g_param_check
    $error("count_bits_engine: WORD_SIZE must be a multiple of STEP");
  end

  state_t               state;
  state_t               state_next;
  mode_t                mode_q;
  logic [WORD_SIZE-1:0] op;
  logic [WORD_SIZE-1:0] op_shift;
  logic [WORD_SIZE-1:0] op_init;
  logic [WORD_SIZE-1:0] data_rev;
  logic [SL_W-1:0]      slices_left;
  logic [SC_W-1:0]      slice_pop;
  logic [SC_W-1:0]      slice_tz;
  logic [SC_W-1:0]      slice_add;
  logic                 slice_has_one;
  logic                 tz_mode;
  logic                 last_slice;
  logic                 finish;
  logic                 accept;

  bit_slice_eval #(
    .STEP (STEP),
    .CW   (SC_W)
  ) u_slice_eval (
    .slice    (op[STEP-1:0]),
    .popcount (slice_pop),
    .tz_count (slice_tz),
    .has_one  (slice_has_one)
  );

  assign data_rev   = WORD_SIZE'(bit_reverse(MAX_WORD'(data)) >> (MAX_WORD - WORD_SIZE));
  assign op_shift   = op >> STEP;
  assign tz_mode    = (mode_q == LEAD_Z) || (mode_q == TRAIL_Z);
  assign last_slice = (slices_left == SL_W'(1));
  assign slice_add  = tz_mode ? slice_tz : slice_pop;
  // Popcount modes stop once nothing is left to count; zero-run modes stop at the first one.
  assign finish     = tz_mode ? (slice_has_one || last_slice) : ((op_shift == '0) || last_slice);
  assign accept     = start && !abort && (state == IDLE || state == DONE);

  always_comb begin
    op_init = data;
    case (mode_t'(mode))
      ZEROS:   op_init = ~data;
      LEAD_Z:  op_init = data_rev;
      default: op_init = data;
    endcase
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (finish) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_next = COUNT;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op          <= '0;
      slices_left <= '0;
      bit_count   <= '0;
      mode_q      <= ONES;
    end else if (abort) begin
      op          <= '0;
      slices_left <= '0;
      bit_count   <= '0;
    end else if (accept) begin
      op          <= op_init;
      slices_left <= SL_W'(SLICES);
      bit_count   <= '0;
      mode_q      <= mode_t'(mode);
    end else if (state == COUNT) begin
      op          <= op_shift;
      slices_left <= slices_left - SL_W'(1);
      bit_count   <= bit_count + CNT_W'(slice_add);
    end
  end

endmodule

// File: tb/tb_count_bits_engine.sv
// tb/tb_count_bits_engine.sv - self-checking bench for count_bits_engine (8/1 and 16/4)
module tb_count_bits_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] data = 16'h0000;

  logic [3:0]  cnt8;
  logic        busy8, done8;
  logic [4:0]  cnt16;
  logic        busy16, done16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  count_bits_engine #(.WORD_SIZE(8), .STEP(1)) u_dut8 (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .data      (data[7:0]),
    .bit_count (cnt8),
    .busy      (busy8),
    .done      (done8)
  );

  count_bits_engine #(.WORD_SIZE(16), .STEP(4)) u_dut16 (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .data      (data),
    .bit_count (cnt16),
    .busy      (busy16),
    .done      (done16)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bits of interest as a plain vector, then arithmetic on it.
  function automatic int wof(input int i); return (i == 0) ? 8 : 16; endfunction
  function automatic int sof(input int i); return (i == 0) ? 1 : 4;  endfunction

  function automatic logic [15:0] interest(input int w, input logic [1:0] md, input logic [15:0] d);
    logic [15:0] m;
    logic [15:0] r;
    m = (w == 16) ? 16'hFFFF : 16'h00FF;
    r = '0;
    case (md)
      2'b00: r = d & m;
      2'b01: r = ~d & m;
      2'b10: for (int i = 0; i < w; i++) r[i] = d[w-1-i];
      default: r = d & m;
    endcase
    return r;
  endfunction

  function automatic int lowest_one(input logic [15:0] v, input int w);
    for (int i = 0; i < w; i++) if (v[i]) return i;
    return w;
  endfunction

  function automatic int highest_len(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic int popc(input logic [15:0] v, input int nbits);
    int s;
    s = 0;
    for (int i = 0; i < nbits; i++) s += int'(v[i]);
    return s;
  endfunction

  function automatic int op_cycles(input int w, input int s, input logic [1:0] md, input logic [15:0] d);
    logic [15:0] v;
    int n;
    v = interest(w, md, d);
    if (md[1]) begin
      n = lowest_one(v, w) / s + 1;
      if (n > w / s) n = w / s;
    end else begin
      n = (highest_len(v) + s - 1) / s;
      if (n < 1) n = 1;
    end
    return n;
  endfunction

  function automatic int partial(input int w, input int s, input logic [1:0] md, input logic [15:0] d, input int k);
    logic [15:0] v;
    int t;
    v = interest(w, md, d);
    if (md[1]) begin
      t = lowest_one(v, w);
      return (t < k * s) ? t : k * s;
    end
    return popc(v, k * s);
  endfunction

  // Model state per instance: 0 idle, 1 counting, 2 done.
  int          m_st [2];
  int          m_k  [2];
  int          m_n  [2];
  logic [1:0]  m_md [2];
  logic [15:0] m_d  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0;
        m_k[i]  = 0;
      end else if (abort) begin
        m_st[i] = 0;
        m_k[i]  = 0;
      end else if (start && m_st[i] != 1) begin
        m_md[i] = mode;
        m_d[i]  = data;
        m_n[i]  = op_cycles(wof(i), sof(i), mode, data);
        m_k[i]  = 0;
        m_st[i] = 1;
      end else if (m_st[i] == 1) begin
        m_k[i]++;
        if (m_k[i] >= m_n[i]) m_st[i] = 2;
      end
    end
  end

  task automatic cmp_inst(input int i, input logic b, input logic dn, input int c);
    int ec;
    ec = (m_st[i] == 0) ? 0 : partial(wof(i), sof(i), m_md[i], m_d[i], m_k[i]);
    chk($sformatf("u%0d busy", wof(i)), int'(b), int'(m_st[i] == 1));
    chk($sformatf("u%0d done", wof(i)), int'(dn), int'(m_st[i] == 2));
    chk($sformatf("u%0d bit_count", wof(i)), c, ec);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, busy8, done8, int'(cnt8));
    cmp_inst(1, busy16, done16, int'(cnt16));
  end

  task automatic run_op(input logic [1:0] md, input logic [15:0] d, input bit poke,
                        output int n8, output int n16);
    n8  = 0;
    n16 = 0;
    @(negedge clk); #1;
    mode = md; data = d; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 0) begin
        chk("accept busy", int'(busy8), 1);
        chk("accept clears count", int'(cnt8), 0);
      end else begin
        if (n8 == 0 && done8) n8 = k;
        if (n16 == 0 && done16) n16 = k;
      end
      if (poke && k == 1) begin
        start = 1'b1; mode = 2'b01; data = ~d;
      end
      if (n8 != 0 && n16 != 0) break;
    end
    chk("u8 done within bound", int'(n8 != 0), 1);
    chk("u16 done within bound", int'(n16 != 0), 1);
  endtask

  initial begin
    int n8, n16;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy8", int'(busy8), 0);
    chk("reset done8", int'(done8), 0);
    chk("reset cnt8", int'(cnt8), 0);
    chk("reset cnt16", int'(cnt16), 0);

    chk("model ones B4 count", partial(8, 1, 2'b00, 16'h00B4, 8), 4);
    chk("model ones B4 cycles", op_cycles(8, 1, 2'b00, 16'h00B4), 8);
    chk("model lead 0100 cycles", op_cycles(16, 4, 2'b10, 16'h0100), 2);
    chk("model lead 28 count", partial(8, 1, 2'b10, 16'h0028, 3), 2);

    run_op(2'b00, 16'h00B4, 1'b0, n8, n16);
    chk("ones B4 cycles", n8, 8);  chk("ones B4 count", int'(cnt8), 4);
    run_op(2'b00, 16'h0005, 1'b0, n8, n16);
    chk("ones 05 cycles", n8, 3);  chk("ones 05 count", int'(cnt8), 2);
    run_op(2'b01, 16'h00FF, 1'b0, n8, n16);
    chk("zeros FF cycles", n8, 1); chk("zeros FF count", int'(cnt8), 0);
    run_op(2'b01, 16'h00F0, 1'b0, n8, n16);
    chk("zeros F0 cycles", n8, 4); chk("zeros F0 count", int'(cnt8), 4);
    run_op(2'b11, 16'h0028, 1'b0, n8, n16);
    chk("trail 28 cycles", n8, 4); chk("trail 28 count", int'(cnt8), 3);
    run_op(2'b10, 16'h0028, 1'b0, n8, n16);
    chk("lead 28 cycles", n8, 3);  chk("lead 28 count", int'(cnt8), 2);
    run_op(2'b11, 16'h0000, 1'b0, n8, n16);
    chk("trail 00 cycles", n8, 8); chk("trail 00 count", int'(cnt8), 8);
    run_op(2'b00, 16'hFFFF, 1'b0, n8, n16);
    chk("w16 ones FFFF cycles", n16, 4); chk("w16 ones FFFF count", int'(cnt16), 16);
    run_op(2'b10, 16'h0100, 1'b0, n8, n16);
    chk("w16 lead 0100 cycles", n16, 2); chk("w16 lead 0100 count", int'(cnt16), 7);

    run_op(2'b00, 16'h00B4, 1'b1, n8, n16);
    chk("start in COUNT cycles", n8, 8); chk("start in COUNT count", int'(cnt8), 4);

    @(negedge clk); #1;
    mode = 2'b11; data = 16'h0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-abort count", int'(cnt8), 2);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort busy", int'(busy8), 0);
    chk("abort done", int'(done8), 0);
    chk("abort count", int'(cnt8), 0);

    @(negedge clk); #1;
    start = 1'b1; abort = 1'b1; mode = 2'b00; data = 16'h00FF;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("abort+start idle busy", int'(busy8), 0);
    chk("abort+start idle count", int'(cnt8), 0);
    run_op(2'b00, 16'h00FF, 1'b0, n8, n16);
    @(negedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("abort+start done done", int'(done8), 0);
    chk("abort+start done busy", int'(busy8), 0);
    chk("abort+start done count", int'(cnt8), 0);

    @(negedge clk); #1;
    start = 1'b1; mode = 2'b00; data = 16'hFFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy8", int'(busy8), 0);
    chk("async reset cnt8", int'(cnt8), 0);
    chk("async reset busy16", int'(busy16), 0);
    chk("async reset cnt16", int'(cnt16), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    run_op(2'b00, 16'h000F, 1'b0, n8, n16);
    chk("post-reset ones 0F cycles", n8, 4);
    chk("post-reset ones 0F count", int'(cnt8), 4);

    repeat (600) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 24) == 0);
      mode  = 2'($urandom_range(0, 3));
      data  = ($urandom_range(0, 3) == 0) ? (16'h0001 << $urandom_range(0, 15))
                                          : 16'($urandom);
    end
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
